// File: rtl/oled_seq_top.sv
// PmodOLED top sequencer: power-up through init, NCH content phases (optionally looped),
// power-down through shutdown on request; owns the single muxed SPI/DC output.
module oled_seq_top #(
  parameter int NCH        = 2,
  parameter int TIMEOUT    = 1_000_000,
  parameter bit AUTO_START = 1'b1,
  parameter bit LOOP       = 1'b0,
  localparam int PW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic           off_req,
  input  logic           init_fin,
  input  logic           init_sdo,
  input  logic           init_sclk,
  input  logic           init_dc,
  output logic           init_en,
  input  logic [NCH-1:0] ph_fin,
  input  logic [NCH-1:0] ph_sdo,
  input  logic [NCH-1:0] ph_sclk,
  input  logic [NCH-1:0] ph_dc,
  output logic [NCH-1:0] ph_en,
  input  logic           off_fin,
  input  logic           off_sdo,
  input  logic           off_sclk,
  input  logic           off_dc,
  output logic           off_en,
  output logic           SDIN,
  output logic           SCLK,
  output logic           DC,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [PW-1:0]  phase,
  output logic [2:0]     dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] LAST_PH = PW'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_GAP   = 3'd2,
    S_PHASE = 3'd3,
    S_DONE  = 3'd4,
    S_SHUT  = 3'd5,
    S_DARK  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [PW-1:0] tgt_q, tgt_d;
  logic          tgt_end_q, tgt_end_d;
  logic          pend_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic blk_fin, blk_sdo, blk_sclk, blk_dc;
  logic timed, timeout_hit, err_set, err_clr;

  // Enable decode and SPI mux: only the enabled block is visible, idle bus is 0/1/0.
  always_comb begin
    init_en  = 1'b0;
    ph_en    = '0;
    off_en   = 1'b0;
    blk_fin  = 1'b0;
    blk_sdo  = 1'b0;
    blk_sclk = 1'b1;
    blk_dc   = 1'b0;
    case (state_q)
      S_INIT: begin
        init_en  = 1'b1;
        blk_fin  = init_fin;
        blk_sdo  = init_sdo;
        blk_sclk = init_sclk;
        blk_dc   = init_dc;
      end
      S_PHASE: begin
        for (int i = 0; i < NCH; i++) begin
          if (ph_q == PW'(i)) begin
            ph_en[i] = 1'b1;
            blk_fin  = ph_fin[i];
            blk_sdo  = ph_sdo[i];
            blk_sclk = ph_sclk[i];
            blk_dc   = ph_dc[i];
          end
        end
      end
      S_SHUT: begin
        off_en   = 1'b1;
        blk_fin  = off_fin;
        blk_sdo  = off_sdo;
        blk_sclk = off_sclk;
        blk_dc   = off_dc;
      end
      default: ;
    endcase
  end

  assign timed       = (state_q == S_INIT) || (state_q == S_PHASE) || (state_q == S_SHUT);
  assign timeout_hit = timed && (cnt_q == CW'(TIMEOUT - 1)) && !blk_fin;

  // Next state; a fin arriving on the timeout cycle takes the normal path.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    tgt_d     = tgt_q;
    tgt_end_d = tgt_end_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q)                  state_d = S_DARK;
        else if (AUTO_START || start) state_d = S_INIT;
      end
      S_INIT: begin
        if (blk_fin) begin
          state_d   = S_GAP;
          tgt_d     = '0;
          tgt_end_d = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_SHUT;
          err_set = 1'b1;
        end
      end
      S_PHASE: begin
        if (blk_fin) begin
          state_d = S_GAP;
          if (ph_q == LAST_PH) begin
            tgt_end_d = 1'b1;
          end else begin
            tgt_d     = ph_q + PW'(1);
            tgt_end_d = 1'b0;
          end
        end else if (timeout_hit) begin
          state_d = S_SHUT;
          err_set = 1'b1;
        end
      end
      S_GAP: begin
        if (pend_q) begin
          state_d = S_SHUT;
        end else if (tgt_end_q) begin
          if (LOOP) begin
            state_d = S_PHASE;
            ph_d    = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_PHASE;
          ph_d    = tgt_q;
        end
      end
      S_DONE: begin
        if (pend_q) begin
          state_d = S_SHUT;
        end else if (start) begin
          state_d   = S_GAP;
          tgt_d     = '0;
          tgt_end_d = 1'b0;
        end
      end
      S_SHUT: begin
        if (blk_fin) begin
          state_d = S_DARK;
        end else if (timeout_hit) begin
          state_d = S_DARK;
          err_set = 1'b1;
        end
      end
      S_DARK: begin
        if (start) begin
          state_d = S_INIT;
          err_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      tgt_q     <= '0;
      tgt_end_q <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      tgt_q     <= tgt_d;
      tgt_end_q <= tgt_end_d;
      if (state_d != state_q)  cnt_q <= '0;
      else if (timed)          cnt_q <= cnt_q + CW'(1);
      // Entering the power-down path consumes the request; otherwise latch new ones.
      if ((state_d != state_q) && ((state_d == S_SHUT) || (state_d == S_DARK)))
        pend_q <= 1'b0;
      else if (off_req && (state_q != S_SHUT) && (state_q != S_DARK))
        pend_q <= 1'b1;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign SDIN      = blk_sdo;
  assign SCLK      = blk_sclk;
  assign DC        = blk_dc;
  assign busy      = (state_q == S_INIT) || (state_q == S_GAP) ||
                     (state_q == S_PHASE) || (state_q == S_SHUT);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign phase     = ph_q;
  assign dbg_state = state_q;

endmodule
